// File: rtl/system_qsys_irq_latency_pkg.sv
// Shared definitions for the IRQ latency monitor: register map,
// control bit positions and FSM state encoding.
package system_qsys_irq_latency_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_LAST   = 3'd2;
  localparam logic [2:0] ADDR_MAX    = 3'd3;
  localparam logic [2:0] ADDR_EVT    = 3'd4;
  localparam logic [2:0] ADDR_CUR    = 3'd5;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/system_qsys_irq_latency_cnt.sv
// Saturating latency counter with a sticky overflow flag.
// Overflow is raised by an increment attempted at full scale; a
// simultaneous clear request loses to that set.
module system_qsys_irq_latency_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             ovf_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count: load 1 on start, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (load_i) begin
      cnt_d    = '0;
      cnt_d[0] = 1'b1;
    end else if (inc_i) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/system_qsys_irq_latency.sv
// IRQ latency monitor: forwards the timer interrupt to the CPU and
// measures how many clk cycles each interrupt pulse stays high.
// Optional feature: define IRQ_LAT_MAX_EN to keep a running maximum
// (address 3); without it that register reads 0.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a rising irq edge while enabled
// ST_MEASURE | irq high, counting cycles until it falls
module system_qsys_irq_latency
  import system_qsys_irq_latency_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq_in,
  output logic        irq_out,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata
);

  state_e           state_q;
  logic             enable_q;
  logic             irq_d_q;
  logic [CNT_W-1:0] last_q;
  logic [15:0]      evt_q;
  logic [15:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cur_cnt;
  logic             overflow;

  logic wr, wr_stat, wr_ctrl, clr, rise, start, inc, capture;

  // Only bits 1:0 of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata[15:2];

  assign irq_out = irq_in;

  assign wr      = chipselect && !write_n;
  assign wr_stat = wr && (address == ADDR_STATUS);
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign clr     = wr_ctrl && writedata[CTRL_CLR_BIT];
  assign rise    = irq_in && !irq_d_q;
  assign start   = (state_q == ST_IDLE)    && enable_q && rise;
  assign inc     = (state_q == ST_MEASURE) && enable_q && irq_in;
  assign capture = (state_q == ST_MEASURE) && enable_q && !irq_in;

  system_qsys_irq_latency_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (start),
    .inc_i     (inc),
    .ovf_clr_i (wr_stat || clr),
    .cnt_o     (cur_cnt),
    .ovf_o     (overflow)
  );

  // FSM, control register and captured results; clear beats capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      irq_d_q  <= 1'b0;
      last_q   <= '0;
      evt_q    <= '0;
    end else begin
      irq_d_q <= irq_in;
      if (wr_ctrl) enable_q <= writedata[CTRL_EN_BIT];
      case (state_q)
        ST_IDLE:    if (start) state_q <= ST_MEASURE;
        ST_MEASURE: if (!enable_q || !irq_in) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
      if (clr) begin
        last_q <= '0;
        evt_q  <= '0;
      end else if (capture) begin
        last_q <= cur_cnt;
        evt_q  <= evt_q + 16'd1;
      end
    end
  end

  logic [15:0] max_rd;
`ifdef IRQ_LAT_MAX_EN
  logic [CNT_W-1:0] max_q;

  // Running maximum of captured latencies.
  always_ff @(posedge clk) begin
    if (!reset_n)                           max_q <= '0;
    else if (clr)                           max_q <= '0;
    else if (capture && (cur_cnt > max_q))  max_q <= cur_cnt;
  end
  assign max_rd = 16'(max_q);
`else
  assign max_rd = 16'd0;
`endif

  // Read mux, zero-extending narrow registers.
  always_comb begin
    rdata_d = 16'd0;
    case (address)
      ADDR_STATUS: rdata_d = {14'd0, overflow, state_q == ST_MEASURE};
      ADDR_CTRL:   rdata_d = {15'd0, enable_q};
      ADDR_LAST:   rdata_d = 16'(last_q);
      ADDR_MAX:    rdata_d = max_rd;
      ADDR_EVT:    rdata_d = evt_q;
      ADDR_CUR:    rdata_d = 16'(cur_cnt);
      default:     rdata_d = 16'd0;
    endcase
  end

  // One-cycle registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) rdata_q <= 16'd0;
    else          rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;

endmodule

// File: doc/system_qsys_irq_latency.md
SYSTEM_QSYS_IRQ_LATENCY -- requirements
Module: system_qsys_irq_latency

Interface
REQ-001 Parameter CNT_W, default 16: width of the latency counter and of the last/max registers; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 irq_in  input  1  level interrupt from the interval timer, sampled on clk.
REQ-005 irq_out  output  1  forwarded interrupt to the CPU; combinational copy of irq_in.
REQ-006 address  input  3  Avalon slave word address.
REQ-007 chipselect  input  1  Avalon slave select.
REQ-008 write_n  input  1  Avalon write strobe, active-low; wr = chipselect && ~write_n.
REQ-009 writedata  input  16  Avalon write data.
REQ-010 readdata  output  16  Avalon read data, registered, with zero wait states and 1-cycle read latency.

Function
REQ-011 The FSM SHALL have states IDLE and MEASURE, and SHALL reset to IDLE.
REQ-012 IDLE -> MEASURE when enable=1, irq_in=1 and irq_d=0, where irq_d is irq_in delayed 1 cycle; on this transition cur_cnt loads 1.
REQ-013 MEASURE, irq_in=1: cur_cnt increments by 1 and saturates at 2^CNT_W-1; an increment attempted at saturation sets sticky overflow.
REQ-014 MEASURE, irq_in=0: last <= cur_cnt; evt_cnt increments (16-bit, wraps 0xFFFF->0); state returns to IDLE; latency = number of cycles irq_in was high.
REQ-015 enable written to 0 while in MEASURE: state goes to IDLE with no capture, and last, max and evt_cnt are unchanged.
REQ-016 irq_in already high when enable goes 1: no measurement starts until the next rising edge.
REQ-017 Register map, read at address A, presented on readdata the next cycle:
  0 status {14'b0, overflow, measuring};
  1 control {15'b0, enable};
  2 last;
  3 max;
  4 evt_cnt;
  5 cur_cnt;
  6..7 read 0.
  Registers narrower than 16 bits are zero-extended.
REQ-018 Writes:
  addr0, any data: clears overflow.
  addr1: bit0 -> enable; bit1=1 pulses clear, which zeroes last, max, evt_cnt and overflow.
  Other addresses: ignored.
REQ-019 Clear in the same cycle as a capture: clear wins and all registers read 0.
REQ-020 Status write in the same cycle as a saturation event: overflow ends set, so set wins over clear.
REQ-021 The module SHALL generate no back-pressure; reads have no side effects.

Reset
REQ-022 On reset_n=0 at a clk edge:
  state=IDLE;
  enable, overflow, cur_cnt, last, max, evt_cnt and irq_d = 0;
  readdata=0.
  irq_out SHALL follow irq_in even during reset.
REQ-023 Reset asserted mid-MEASURE aborts the measurement with no capture.

Configuration
REQ-024 Macro IRQ_LAT_MAX_EN, when defined: on each capture, max <= last-candidate if cur_cnt > max.
REQ-025 Without IRQ_LAT_MAX_EN: the max register and comparator are absent, and address 3 reads 0.

Structure
REQ-026 A shared package (system_qsys_irq_latency_pkg) SHALL hold:
  register address constants ADDR_STATUS..ADDR_CUR;
  the FSM state enum;
  control bit indices.
REQ-027 One sub-module, system_qsys_irq_latency_cnt, SHALL implement the saturating counter with its overflow flag; the FSM, register file and read mux stay in the top module.

Verification
REQ-028 Enable=1, irq_in high for 37 cycles then low -> last=37, evt_cnt=1, max=37 (with EN), status=0.
REQ-029 Two pulses of 50 then 20 cycles -> last=20, max=50 (with EN) or address 3 reads 0 (without EN), evt_cnt=2.
REQ-030 CNT_W=4, irq_in high for 20 cycles -> cur_cnt=15 held, overflow=1, last=15; then write addr0 -> status reads 0.
REQ-031 Enable cleared at cycle 10 of a pulse -> state IDLE, last and evt_cnt unchanged; irq_in high at re-enable -> no count until the next rising edge.
REQ-032 Control write 0x3 in the same cycle irq_in falls -> last=max=evt_cnt=0 and enable=1.
REQ-033 reset_n=0 pulsed mid-MEASURE -> all registers read 0 and irq_out still tracks irq_in.
